// File: rtl/mpfifo_pkg.sv
// Shared helpers for the multi-lane synchronous FIFO.
// Optional request clamping is selected with the MPFIFO_REQ_CHECK_EN macro
// in the top level; nothing here depends on it.
package mpfifo_pkg;

  // Default geometry of a fetch/decode queue instance
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_PUSH_LANES = 2;
  localparam int DEF_POP_LANES  = 4;

  // Smaller of two values; used for the saturated lane counts
  function automatic int sat_min(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Bits needed to hold a count in the range 0..n
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/multiport_sync_fifo_if.sv
// Request/response bundle of the multi-lane FIFO.
// master = producer/consumer side, slave = the FIFO itself.
interface multiport_sync_fifo_if
  import mpfifo_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PUSH_LANES = DEF_PUSH_LANES,
  parameter int POP_LANES  = DEF_POP_LANES
);

  logic                               flush;
  logic [cnt_w(PUSH_LANES)-1:0]       push_cnt;
  logic [DATA_WIDTH-1:0]              data_in  [PUSH_LANES];
  logic [cnt_w(POP_LANES)-1:0]        pop_cnt;
  logic [DATA_WIDTH-1:0]              data_out [POP_LANES];
  logic [cnt_w(POP_LANES)-1:0]        ready_cnt;
  logic [cnt_w(PUSH_LANES)-1:0]       free_cnt;
  logic [cnt_w(DEPTH)-1:0]            count;
  logic                               full;
  logic                               empty;
  logic                               err;

  modport master (
    output flush, push_cnt, data_in, pop_cnt,
    input  data_out, ready_cnt, free_cnt, count, full, empty, err
  );

  modport slave (
    input  flush, push_cnt, data_in, pop_cnt,
    output data_out, ready_cnt, free_cnt, count, full, empty, err
  );

endinterface

// File: rtl/mpfifo_storage.sv
// Entry storage: PUSH_LANES write ports starting at wr_ptr and
// POP_LANES combinational show-ahead read ports starting at rd_ptr.
// Contents are deliberately not reset.
module mpfifo_storage
  import mpfifo_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PUSH_LANES = DEF_PUSH_LANES,
  parameter int POP_LANES  = DEF_POP_LANES
) (
  input  logic                              clk,
  input  logic [$clog2(DEPTH)-1:0]          wr_ptr,
  input  logic [cnt_w(PUSH_LANES)-1:0]      wr_cnt,
  input  logic [DATA_WIDTH-1:0]             wr_data [PUSH_LANES],
  input  logic [$clog2(DEPTH)-1:0]          rd_ptr,
  output logic [DATA_WIDTH-1:0]             rd_data [POP_LANES]
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = cnt_w(PUSH_LANES);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_addr [PUSH_LANES];
  logic [PUSH_LANES-1:0] wr_en;

  // Lane j writes slot wr_ptr+j (natural wrap) when j is below the admitted count
  for (genvar gi = 0; gi < PUSH_LANES; gi++) begin : g_wr
    assign wr_addr[gi] = wr_ptr + AW'(gi);
    assign wr_en[gi]   = (PW'(gi) < wr_cnt);
  end

  // All admitted lanes land on distinct slots, so one block serves every write port
  always_ff @(posedge clk) begin
    for (int j = 0; j < PUSH_LANES; j++) begin
      if (wr_en[j]) begin
        mem[wr_addr[j]] <= wr_data[j];
      end
    end
  end

  // Read lane i shows the i-th oldest slot regardless of occupancy; the top masks it
  for (genvar gi = 0; gi < POP_LANES; gi++) begin : g_rd
    assign rd_data[gi] = mem[rd_ptr + AW'(gi)];
  end

endmodule

// File: rtl/multiport_sync_fifo.sv
// Multi-lane synchronous FIFO: up to PUSH_LANES enqueues and POP_LANES
// dequeues per cycle, in order, show-ahead head lanes, pipeline flush.
// Optional feature macro: MPFIFO_REQ_CHECK_EN -- when defined, over-sized
// requests are clamped and flagged on a sticky err; otherwise err is 0 and
// simulation assertions catch illegal requests.
module multiport_sync_fifo
  import mpfifo_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PUSH_LANES = DEF_PUSH_LANES,
  parameter int POP_LANES  = DEF_POP_LANES
) (
  input  logic                       clk,
  input  logic                       rst,
  multiport_sync_fifo_if.slave       bus
);

  localparam int AW   = $clog2(DEPTH);
  localparam int PW   = cnt_w(PUSH_LANES);
  localparam int POPW = cnt_w(POP_LANES);
  localparam int CW   = cnt_w(DEPTH);
  localparam int CWX  = CW + 1;

  logic [AW-1:0]         rd_ptr_reg;
  logic [AW-1:0]         wr_ptr_reg;
  logic [CW-1:0]         count_reg;
  logic [POPW-1:0]       ready_cnt_w;
  logic [PW-1:0]         free_cnt_w;
  logic [POPW-1:0]       pop_eff;
  logic [PW-1:0]         push_eff;
  logic [PW-1:0]         wr_cnt;
  logic [DATA_WIDTH-1:0] rd_data [POP_LANES];

  // Lane availability is derived from registered occupancy only
  always_comb begin
    ready_cnt_w = POPW'(sat_min(int'(count_reg), POP_LANES));
    free_cnt_w  = PW'(sat_min(DEPTH - int'(count_reg), PUSH_LANES));
  end

`ifdef MPFIFO_REQ_CHECK_EN
  logic req_bad;
  logic err_reg;

  // Clamp each request to what the pre-edge state allows; the excess is dropped
  always_comb begin
    req_bad  = (bus.pop_cnt > ready_cnt_w) || (bus.push_cnt > free_cnt_w);
    pop_eff  = POPW'(sat_min(int'(bus.pop_cnt), int'(ready_cnt_w)));
    push_eff = PW'(sat_min(int'(bus.push_cnt), int'(free_cnt_w)));
  end

  // Sticky error: set by any clamped request, cleared only by reset, held across flush
  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (!bus.flush && req_bad) begin
      err_reg <= 1'b1;
    end
  end

  assign bus.err = err_reg;
`else
  // Requests are trusted as-is; the environment must keep them legal
  always_comb begin
    pop_eff  = bus.pop_cnt;
    push_eff = bus.push_cnt;
  end

  assign bus.err = 1'b0;

`ifndef SYNTHESIS
  // An unflushed request may not exceed the pre-edge ready/free lane counts
  req_legal_a: assert property (@(posedge clk) disable iff (rst)
    !bus.flush |-> (bus.pop_cnt <= ready_cnt_w && bus.push_cnt <= free_cnt_w));
`endif
`endif

  // Reset and flush suppress the storage writes of that edge
  assign wr_cnt = (rst || bus.flush) ? '0 : push_eff;

  // Pointer/occupancy update with priority reset > flush > normal traffic
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_reg + AW'(pop_eff);
      wr_ptr_reg <= wr_ptr_reg + AW'(push_eff);
      count_reg  <= CW'(CWX'(count_reg) + CWX'(push_eff) - CWX'(pop_eff));
    end
  end

  mpfifo_storage #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .PUSH_LANES (PUSH_LANES),
    .POP_LANES  (POP_LANES)
  ) u_storage (
    .clk     (clk),
    .wr_ptr  (wr_ptr_reg),
    .wr_cnt  (wr_cnt),
    .wr_data (bus.data_in),
    .rd_ptr  (rd_ptr_reg),
    .rd_data (rd_data)
  );

  // Head lanes beyond current occupancy read as zero rather than stale slots
  for (genvar gi = 0; gi < POP_LANES; gi++) begin : g_out
    assign bus.data_out[gi] = (POPW'(gi) < ready_cnt_w) ? rd_data[gi] : '0;
  end

  assign bus.ready_cnt = ready_cnt_w;
  assign bus.free_cnt  = free_cnt_w;
  assign bus.count     = count_reg;
  assign bus.full      = (count_reg == CW'(DEPTH));
  assign bus.empty     = (count_reg == '0);

endmodule

// File: tb/tb_multiport_sync_fifo.sv
// Bench for multiport_sync_fifo: table of hand-computed vectors, directed
// corner sequences, then random traffic against a queue-based model.
module tb_multiport_sync_fifo;

  localparam int DEPTH      = 16;
  localparam int DATA_WIDTH = 32;
  localparam int PUSH_LANES = 2;
  localparam int POP_LANES  = 4;
  localparam int PW         = $clog2(PUSH_LANES + 1);
  localparam int POPW       = $clog2(POP_LANES + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;

  multiport_sync_fifo_if #(
    .DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH),
    .PUSH_LANES(PUSH_LANES), .POP_LANES(POP_LANES)
  ) bus ();

  multiport_sync_fifo #(
    .DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH),
    .PUSH_LANES(PUSH_LANES), .POP_LANES(POP_LANES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the FIFO contents as a plain queue, oldest first
  logic [31:0] q[$];
  bit          err_m;

  typedef struct {
    bit          flush;
    int          push;
    int          pop;
    logic [31:0] d0, d1;
    int          e_count, e_ready, e_free;
    logic [31:0] e_q0, e_q1, e_q2, e_q3;
  } vec_t;

  vec_t tbl[8];

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model by the FIFO rules, clock it
  task automatic cycle(input bit r, input bit f, input int push, input int pop,
                       input logic [31:0] d0, input logic [31:0] d1);
    int sz, rdy, fr, pe, ue;
    rst             = r;
    bus.flush       = f;
    bus.push_cnt    = PW'(push);
    bus.pop_cnt     = POPW'(pop);
    bus.data_in[0]  = d0;
    bus.data_in[1]  = d1;
    sz  = q.size();
    rdy = imin(sz, POP_LANES);
    fr  = imin(DEPTH - sz, PUSH_LANES);
    pe  = pop;
    ue  = push;
    if (r) begin
      q.delete();
      err_m = 1'b0;
    end else if (f) begin
      q.delete();
    end else begin
      if (pop > rdy || push > fr) begin
`ifdef MPFIFO_REQ_CHECK_EN
        err_m = 1'b1;
        pe = imin(pop, rdy);
        ue = imin(push, fr);
`endif
      end
      repeat (pe) void'(q.pop_front());
      if (ue > 0) q.push_back(d0);
      if (ue > 1) q.push_back(d1);
    end
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.flush    = 1'b0;
    bus.push_cnt = '0;
    bus.pop_cnt  = '0;
  endtask

  task automatic check_model(input string tag);
    int sz;
    sz = q.size();
    chk({tag, ".count"}, 32'(bus.count), sz);
    chk({tag, ".ready"}, 32'(bus.ready_cnt), imin(sz, POP_LANES));
    chk({tag, ".free"},  32'(bus.free_cnt), imin(DEPTH - sz, PUSH_LANES));
    chk({tag, ".full"},  32'(bus.full), (sz == DEPTH) ? 1 : 0);
    chk({tag, ".empty"}, 32'(bus.empty), (sz == 0) ? 1 : 0);
    chk({tag, ".err"},   32'(bus.err), 32'(err_m));
    for (int i = 0; i < POP_LANES; i++) begin
      chk($sformatf("%s.data_out%0d", tag, i), bus.data_out[i], (i < sz) ? q[i] : 32'h0);
    end
  endtask

  initial begin
    logic [31:0] seq;
    bus.flush = 1'b0;
    bus.push_cnt = '0;
    bus.pop_cnt = '0;
    bus.data_in[0] = '0;
    bus.data_in[1] = '0;

    //            flush push pop d0      d1      cnt rdy fr  q0      q1      q2      q3
    tbl[0] = '{1'b0, 2, 0, 32'hA,  32'hB,  2, 2, 2, 32'hA,  32'hB,  32'h0, 32'h0};
    tbl[1] = '{1'b0, 2, 0, 32'hC,  32'hD,  4, 4, 2, 32'hA,  32'hB,  32'hC, 32'hD};
    tbl[2] = '{1'b0, 1, 1, 32'hE,  32'h0,  4, 4, 2, 32'hB,  32'hC,  32'hD, 32'hE};
    tbl[3] = '{1'b0, 0, 4, 32'h0,  32'h0,  0, 0, 2, 32'h0,  32'h0,  32'h0, 32'h0};
    tbl[4] = '{1'b0, 1, 0, 32'hF,  32'h0,  1, 1, 2, 32'hF,  32'h0,  32'h0, 32'h0};
    tbl[5] = '{1'b1, 2, 0, 32'h6,  32'h7,  0, 0, 2, 32'h0,  32'h0,  32'h0, 32'h0};
    tbl[6] = '{1'b0, 2, 0, 32'h58, 32'h59, 2, 2, 2, 32'h58, 32'h59, 32'h0, 32'h0};
    tbl[7] = '{1'b0, 0, 2, 32'h0,  32'h0,  0, 0, 2, 32'h0,  32'h0,  32'h0, 32'h0};

    // Reset, then idle: fresh-FIFO outputs
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("rst.empty", 32'(bus.empty), 1);
    chk("rst.count", 32'(bus.count), 0);
    chk("rst.ready", 32'(bus.ready_cnt), 0);
    chk("rst.free",  32'(bus.free_cnt), 2);
    chk("rst.full",  32'(bus.full), 0);
    chk("rst.err",   32'(bus.err), 0);
    for (int i = 0; i < POP_LANES; i++) chk($sformatf("rst.data_out%0d", i), bus.data_out[i], 0);

    // Table vectors
    for (int v = 0; v < 8; v++) begin
      cycle(0, tbl[v].flush, tbl[v].push, tbl[v].pop, tbl[v].d0, tbl[v].d1);
      chk($sformatf("vec%0d.count", v), 32'(bus.count), tbl[v].e_count);
      chk($sformatf("vec%0d.ready", v), 32'(bus.ready_cnt), tbl[v].e_ready);
      chk($sformatf("vec%0d.free", v),  32'(bus.free_cnt), tbl[v].e_free);
      chk($sformatf("vec%0d.q0", v), bus.data_out[0], tbl[v].e_q0);
      chk($sformatf("vec%0d.q1", v), bus.data_out[1], tbl[v].e_q1);
      chk($sformatf("vec%0d.q2", v), bus.data_out[2], tbl[v].e_q2);
      chk($sformatf("vec%0d.q3", v), bus.data_out[3], tbl[v].e_q3);
    end

    // Fill to DEPTH, then pop 3 alongside a push that has no room
    for (int k = 0; k < 8; k++) cycle(0, 0, 2, 0, 32'h100 + 2 * k, 32'h101 + 2 * k);
    chk("fill.count", 32'(bus.count), 16);
    chk("fill.full",  32'(bus.full), 1);
    chk("fill.free",  32'(bus.free_cnt), 0);
    chk("fill.ready", 32'(bus.ready_cnt), 4);
`ifdef MPFIFO_REQ_CHECK_EN
    cycle(0, 0, 2, 3, 32'hDEAD, 32'hBEEF);
    chk("fullpush.err", 32'(bus.err), 1);
`else
    cycle(0, 0, 0, 3, 32'hDEAD, 32'hBEEF);
    chk("fullpush.err", 32'(bus.err), 0);
`endif
    chk("fullpush.count", 32'(bus.count), 13);
    chk("fullpush.q0", bus.data_out[0], 32'h103);
    check_model("fullpush");

    // Reset mid-stream with a 4-entry pop pending
    cycle(1, 0, 0, 4, 0, 0);
    chk("midrst.count", 32'(bus.count), 0);
    chk("midrst.err",   32'(bus.err), 0);
    chk("midrst.free",  32'(bus.free_cnt), 2);
    check_model("midrst");

    // Steady push 2 / pop 2 across many pointer wraps
    cycle(0, 0, 2, 0, 0, 1);
    cycle(0, 0, 2, 0, 2, 3);
    seq = 4;
    for (int k = 0; k < 40; k++) begin
      cycle(0, 0, 2, 2, seq, seq + 1);
      seq += 2;
      chk($sformatf("wrap%0d.q0", k), bus.data_out[0], 32'(2 * (k + 1)));
      check_model($sformatf("wrap%0d", k));
    end

    // Flush at count 7 with a concurrent push, then a single push
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 2, 0, 32'h200, 32'h201);
    cycle(0, 0, 2, 0, 32'h202, 32'h203);
    cycle(0, 0, 2, 0, 32'h204, 32'h205);
    cycle(0, 0, 1, 0, 32'h206, 32'h0);
    chk("preflush.count", 32'(bus.count), 7);
    cycle(0, 1, 2, 0, 32'h300, 32'h301);
    chk("flush.count", 32'(bus.count), 0);
    chk("flush.empty", 32'(bus.empty), 1);
    cycle(0, 0, 1, 0, 32'hCAFE, 32'h0);
    chk("postflush.q0",    bus.data_out[0], 32'hCAFE);
    chk("postflush.count", 32'(bus.count), 1);
    check_model("postflush");

    // Random traffic in three phases: filling, balanced, draining
    cycle(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 300; k++) begin
      int sz, push, pop, pmax;
      bit f;
      sz   = q.size();
      pmax = (k < 100) ? 1 : (k < 200) ? 2 : 4;
      f    = ($urandom_range(0, 24) == 0);
`ifdef MPFIFO_REQ_CHECK_EN
      push = $urandom_range(0, PUSH_LANES);
      pop  = $urandom_range(0, pmax);
`else
      push = $urandom_range(0, imin(DEPTH - sz, PUSH_LANES));
      pop  = $urandom_range(0, imin(sz, pmax));
`endif
      cycle(0, f, push, pop, $urandom, $urandom);
      check_model($sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
